regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a busy scoreboard and a self-zeroing INIT sweep.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   we0/waddr0/wdata0      write port 0
//   we1/waddr1/wdata1      write port 1 (wins over port 0 on the same address)
//   re, raddr              per-port read enable and packed read addresses
//   rdata                  packed combinational read data (with write bypass when re is set)
//   rbusy                  scoreboard busy bit of the register each read port addresses
//   alloc_en, alloc_addr   mark a register busy (a writer has been issued)
//   clr                    re-initialise every register to zero
//   ready                  high once the sweep has finished and the file is usable
//
// Register 0 always reads zero and is never marked busy.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    input  logic                  clr,
    output logic                  ready
);

    localparam int unsigned N = 2 ** ADDR_W;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]      busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [N];

    logic run;
    logic upd;
    logic wr0;
    logic wr1;

    assign run   = (state_q == StRun);
    assign ready = run;

    // clr in RUN suppresses any write or alloc in the same cycle.
    assign upd = run && !clr;
    assign wr0 = upd && we0 && (waddr0 != '0);
    assign wr1 = upd && we1 && (waddr1 != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clr) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    busy_d  = '0;
                end else begin
                    if (wr0) busy_d[waddr0] = 1'b0;
                    if (wr1) busy_d[waddr1] = 1'b0;
                    // Alloc applied last: a new writer issued this cycle stays pending.
                    if (alloc_en && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the INIT sweep zeroes it before ready rises.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0) mem_q[waddr0] <= wdata0;
            if (wr1) mem_q[waddr1] <= wdata1;
        end
    end

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] lane;

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        lane  = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            ra   = raddr[i*ADDR_W +: ADDR_W];
            lane = '0;
            if (run && (ra != '0)) begin
                if (re[i] && we1 && (waddr1 == ra)) begin
                    lane = wdata1;
                end else if (re[i] && we0 && (waddr0 == ra)) begin
                    lane = wdata0;
                end else begin
                    lane = mem_q[ra];
                end
                rbusy[i] = busy_q[ra];
            end
            rdata[i*DATA_W +: DATA_W] = lane;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NREG = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;
    logic             clr;
    logic             ready;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr        (clr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Model: the file is unusable until NREG edges have elapsed since reset/clr; at that
    // point every register is zero. In use, writes and allocs follow the stated rules.
    bit          m_ready = 1'b0;
    int          m_edges = 0;
    bit          m_busy [NREG];
    logic [DW-1:0] m_mem [NREG];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0;
            m_edges = 0;
            foreach (m_busy[k]) m_busy[k] = 1'b0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == NREG) begin
                m_ready = 1'b1;
                foreach (m_mem[k]) m_mem[k] = '0;
            end
        end else if (clr) begin
            m_ready = 1'b0;
            m_edges = 0;
            foreach (m_busy[k]) m_busy[k] = 1'b0;
        end else begin
            if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    end

    task automatic lit(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_lane(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (!m_ready || a == 0) return '0;
        if (re[i] && we1 && waddr1 == a) return wdata1;
        if (re[i] && we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (!m_ready || a == 0) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        lit("ready", {31'b0, ready}, {31'b0, m_ready});
        for (int i = 0; i < NR; i++) begin
            lit($sformatf("rdata[%0d]", i), rdata[i*DW +: DW], exp_lane(i));
            lit($sformatf("rbusy[%0d]", i), {31'b0, rbusy[i]}, {31'b0, exp_busy(i)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; alloc_en = 0; clr = 0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic en);
        raddr[p*AW +: AW] = a;
        re[p] = en;
    endtask

    task automatic sweep_check(input string name);
        for (int k = 1; k <= NREG; k++) begin
            step();
            lit(name, {31'b0, ready}, (k == NREG) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        re = 0; raddr = 0; alloc_en = 0; alloc_addr = 0; clr = 0;
        rd(0, 5'd3, 1'b0);
        rd(1, 5'd5, 1'b0);
        repeat (3) step();
        lit("ready in reset", {31'b0, ready}, 32'd0);
        lit("rdata in reset", rdata[31:0], 32'd0);

        // Release reset, ready after exactly 32 edges.
        rst = 1'b1;
        sweep_check("ready during first sweep");
        lit("reg3 after sweep", rdata[31:0], 32'd0);

        // Same-cycle write bypass, then stored value.
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
        rd(0, 5'd3, 1'b1);
        #1 lit("bypass w0", rdata[31:0], 32'hA5A5A5A5);
        step(); idle();
        #1 lit("stored reg3", rdata[31:0], 32'hA5A5A5A5);

        // Port 1 priority on the same address.
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
        rd(0, 5'd7, 1'b1);
        #1 lit("bypass w1 priority", rdata[31:0], 32'h22);
        step(); idle();
        rd(0, 5'd7, 1'b0);
        #1 lit("stored reg7", rdata[31:0], 32'h22);

        // Address 0 discards writes, even with bypass enabled.
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFF;
        rd(0, 5'd0, 1'b1);
        #1 lit("bypass addr0", rdata[31:0], 32'd0);
        step(); idle();
        #1 lit("read addr0", rdata[31:0], 32'd0);

        // Scoreboard.
        rd(1, 5'd9, 1'b0);
        alloc_en = 1; alloc_addr = 5'd9;
        #1 lit("busy no bypass", {31'b0, rbusy[1]}, 32'd0);
        step(); idle();
        #1 lit("busy after alloc", {31'b0, rbusy[1]}, 32'd1);
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h5;
        step(); idle();
        #1 lit("busy after write", {31'b0, rbusy[1]}, 32'd0);
        alloc_en = 1; alloc_addr = 5'd9;
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'h6;
        step(); idle();
        #1 lit("busy alloc+write", {31'b0, rbusy[1]}, 32'd1);

        // clr re-initialises; clr beats a same-cycle write.
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'h1234;
        alloc_en = 1; alloc_addr = 5'd4;
        step(); idle();
        rd(0, 5'd4, 1'b0);
        rd(1, 5'd5, 1'b0);
        #1 lit("reg4 before clr", rdata[31:0], 32'h1234);
        lit("busy4 before clr", {31'b0, rbusy[0]}, 32'd1);
        clr = 1;
        we1 = 1; waddr1 = 5'd5; wdata1 = 32'h55;
        step(); idle();
        #1 lit("busy4 after clr", {31'b0, rbusy[0]}, 32'd0);
        // Writes and allocs are ignored while sweeping.
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'hDEAD;
        alloc_en = 1; alloc_addr = 5'd4;
        sweep_check("ready during clr sweep");
        idle();
        #1 lit("reg4 after clr", rdata[31:0], 32'd0);
        lit("reg5 clr beats write", rdata[63:32], 32'd0);
        lit("busy4 after clr sweep", {31'b0, rbusy[0]}, 32'd0);

        // Reset mid-RUN takes effect asynchronously.
        we0 = 1; waddr0 = 5'd4; wdata0 = 32'h77;
        alloc_en = 1; alloc_addr = 5'd4;
        step(); idle();
        #1 lit("reg4 before rst", rdata[31:0], 32'h77);
        #1 rst = 1'b0;
        #1 lit("ready async rst", {31'b0, ready}, 32'd0);
        lit("rdata async rst", rdata[31:0], 32'd0);
        lit("rbusy async rst", {31'b0, rbusy[0]}, 32'd0);
        step();
        rst = 1'b1;
        // Reset again at sweep counter 10; full sweep must follow.
        repeat (10) step();
        rst = 1'b0;
        #1 lit("ready rst mid-init", {31'b0, ready}, 32'd0);
        step();
        rst = 1'b1;
        sweep_check("ready after mid-init rst");
        lit("reg4 after rst sweep", rdata[31:0], 32'd0);
        lit("busy4 after rst sweep", {31'b0, rbusy[0]}, 32'd0);

        // Mixed traffic on a small address window, checked by the model.
        for (int c = 0; c < 60; c++) begin
            we0 = 1'($urandom); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
            we1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
            alloc_en = 1'($urandom); alloc_addr = 5'($urandom_range(0, 7));
            re = 2'($urandom);
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
